// File: rtl/times_table_arbiter.sv
// Round-robin arbiter sharing the single-port times-table BRAM between two
// lookup clients; tracks the requester of each in-flight read and routes the product back.
module times_table_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] a0,
   input  logic [2:0] b0,
   input  logic [2:0] a1,
   input  logic [2:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       rvalid0,
   output logic       rvalid1,
   output logic [5:0] rdata0,
   output logic [5:0] rdata1,
   output logic       bram_en,
   output logic [5:0] bram_addr,
   input  logic [5:0] bram_dout,
   output logic       busy
);

   typedef struct packed {
      logic valid;
      logic id;
   } track_t;

   logic   prio;
   logic   prio_next;
   logic   xfer;
   logic   gnt_id;
   track_t pipe [RD_LAT];
   track_t last;

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of process ordering.
      if (!rst_n) prio <= 1'b0;
      else        prio <= prio_next;
   end

   // Pointer moves to the requester that was not just served.
   always_comb begin
      prio_next = prio;
      if (xfer) prio_next = ~gnt_id;
   end

   // Grant decode: pointer only matters under contention.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0 && req1) begin
         gnt0 = ~prio;
         gnt1 = prio;
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
   end

   assign xfer    = gnt0 | gnt1;
   assign gnt_id  = gnt1;
   assign bram_en = req0 | req1;

   always_comb begin
      bram_addr = 6'd0;
      if (gnt0)      bram_addr = {a0, b0};
      else if (gnt1) bram_addr = {a1, b1};
   end

   // Requester-ID tracking through the BRAM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the tracking stages are a handful of flops, not a RAM, so
         // clearing them in reset is cheap and guarantees in-flight lookups die.
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{valid: xfer, id: gnt_id};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign last = pipe[RD_LAT-1];

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < RD_LAT; i++) busy = busy | pipe[i].valid;
   end

   // Return path: capture the product for whichever requester issued it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= 6'd0;
         rdata1  <= 6'd0;
      end else begin
         rvalid0 <= last.valid && !last.id;
         rvalid1 <= last.valid &&  last.id;
         if (last.valid && !last.id) rdata0 <= bram_dout;
         if (last.valid &&  last.id) rdata1 <= bram_dout;
      end
   end

endmodule

// File: doc/times_table_arbiter.md
# times_table_arbiter

Two-requester round-robin arbiter that shares the single-port times-table block RAM (`mybram`, 64×6, address `{a,b}`, read-only) between two independent lookup clients. It grants at most one lookup per cycle, drives the BRAM enable and address, tracks the in-flight requester ID through the BRAM read latency, and returns each 6-bit product to the requester that issued it. The arbiter sits between the lookup clients and the `mybram` instance; the BRAM write port stays tied off (`wea = 0`).

## Interface
Parameters:
- `RD_LAT`, default 1: BRAM read latency in cycles from the address-sampling edge to valid `douta`. Legal values are 1 or 2.

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `req0`, `req1`  input  1 each  lookup request, level; each is held until granted.
- `a0`, `b0`, `a1`, `b1`  input  3 each  operands; stable while the matching `req` is high.
- `gnt0`, `gnt1`  output  1 each  combinational grant; a transfer occurs on any edge where `req_i && gnt_i`.
- `rvalid0`, `rvalid1`  output  1 each  one-cycle pulse when `rdata_i` is updated.
- `rdata0`, `rdata1`  output  6 each  last product returned to that requester; held between pulses.
- `bram_en`  output  1  to `mybram.ena`.
- `bram_addr`  output  6  to `mybram.addra`.
- `bram_dout`  input  6  from `mybram.douta`.
- `busy`  output  1  high while any lookup is in flight in the tracking pipeline.

## Operation
- **Round-robin pointer `prio`** (1 bit; 0 means requester 0 has priority).
  - Both `req` high: grant `prio`.
  - Only one `req` high: grant that requester.
  - On every transfer, `prio` is set to the other requester (not the one just granted).
  - No transfer: `prio` is unchanged.
- **Grant logic:**
  - `gnt0`/`gnt1` are combinational from `req0`, `req1` and `prio`.
  - The two grants are never both high.
  - A grant is never asserted without its matching `req`.
- **BRAM drive (combinational):**
  - `bram_en = req0 | req1`.
  - `bram_addr = {a_g, b_g}` of the granted requester; it is 0 when no request is present.
- **Tracking pipeline:**
  - `RD_LAT`-deep shift register of `{valid, id}`.
  - On a transfer, `{1, granted id}` enters stage 0; otherwise `{0, x}` enters.
- **Return:** when the last stage is valid, at that edge:
  - `rdata_id <= bram_dout` and `rvalid_id <= 1`.
  - The other requester's `rdata` is unchanged.
  - `rvalid` is cleared on every edge without a return.
- **`busy`:** OR of all pipeline valid bits.
- **Arithmetic:** the product is the `bram_dout` value as-is, unsigned 0..49. No width conversion or saturation.
- **Back-to-back:**
  - A requester may keep `req` high after a grant to issue another lookup, with new or unchanged operands.
  - When both requesters are continuously requesting, grants alternate 0,1,0,1…
  - Throughput is one lookup per cycle total.
- **No stall:** the BRAM cannot back-pressure, and returns are never dropped or reordered.

## Timing
- **Reset values (asynchronous on `rst_n` low):**
  - `prio = 0`.
  - All pipeline valid bits 0.
  - `rvalid0 = rvalid1 = 0`, `rdata0 = rdata1 = 0`, `busy = 0`.
  - `gnt`, `bram_en` and `bram_addr` follow inputs combinationally, even during reset.
- **Reset mid-operation:** in-flight lookups are discarded, and no `rvalid` is produced for them after release.
- **Latency:**
  - Transfer at edge E; BRAM samples the address at E.
  - `rdata`/`rvalid` are registered at edge E+`RD_LAT`.
  - `rvalid` is high during cycle E+`RD_LAT`..E+`RD_LAT`+1.
  - With `RD_LAT=1`, the result is visible one cycle after the grant edge.
- **Simultaneous events:**
  - A return and a new transfer in the same cycle are independent.
  - Returns to both requesters on consecutive edges give consecutive single-cycle pulses.
- **Operand changes:** a requester changing `a`/`b` while `req` is high and not granted has undefined ordering. The requirement on requesters is operand stability until the grant.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with lookups in flight → all outputs at reset values, and no `rvalid` for 3 cycles after release.
- **Single lookup:** `req0` only, `a0=3`, `b0=5`, `RD_LAT=1` → `gnt0=1`, `bram_addr=6'b011101`; next cycle `rvalid0=1`, `rdata0=15`; `rdata1` stays 0.
- **Contention from reset:** both requesters continuously requesting, `a0=7,b0=7`, `a1=2,b1=6` → grants 0,1,0,1; `rdata0=49` and `rdata1=12` pulse on alternating cycles.
- **Pointer after solo grant:** `req1` alone granted, then both request → `gnt0` first.
- **`RD_LAT=2`:** `req0`, `a0=4`, `b0=4` → `rvalid0`/`rdata0=16` two cycles after the grant edge; `busy` high for exactly 2 cycles.
- **Back-to-back:** `req0` held 4 cycles with `b0` stepping 0..3, `a0=6` → `rdata0` = 0, 6, 12, 18 on 4 consecutive `rvalid0` pulses.
